// File: rtl/seq_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM encoding,
// length-field width and the effective-length rule.
package seq_tx_pkg;

  localparam int LEN_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10,
    DONE  = 2'b11
  } state_t;

  // A zero or oversized length means "send the whole register".
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len_in,
                                               input logic [LEN_W-1:0] width);
    logic [LEN_W-1:0] w_len;
    if ((len_in == {LEN_W{1'b0}}) || (len_in > width)) begin
      w_len = width;
    end else begin
      w_len = len_in;
    end
    return w_len;
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load, MSB-out shift register; load takes priority over shift.
module piso_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] r_sr;

  // Register contents: clear on reset, parallel load, or shift toward the MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr <= {W{1'b0}};
    end else if (load) begin
      r_sr <= din;
    end else if (shift) begin
      r_sr <= {r_sr[W-2:0], 1'b0};
    end
  end

  assign msb = r_sr[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: sends pattern[L-1:0] MSB-first, repeat_n+1 times
// with idle-level gaps, then pulses done. All outputs come straight from flops.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int   W          = 8,
  parameter int   GAP_CYCLES = 2,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [W-1:0]     pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [3:0]       repeat_n,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = $clog2(W + 1);
  localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES == 0) ? {GAP_W{1'b0}}
                                                            : GAP_W'(GAP_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_pat_al;
  logic [BIT_W-1:0] r_len;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [3:0]       r_rep;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_dout;
  logic             r_dout_valid;
  logic             r_busy;
  logic             r_done;

  logic [LEN_W-1:0] w_eff;
  logic [W-1:0]     w_cap_al;
  logic             w_msb;
  logic             w_load;
  logic             w_shift;
  logic [W-1:0]     w_din;
  logic             w_dout_nxt;
  logic             w_capture;
  logic             w_reload;
  logic             w_bit_dec;
  logic             w_rep_dec;
  logic             w_gap_load;
  logic             w_gap_dec;

  // The captured pattern is left-aligned so the first frame bit sits at the MSB.
  assign w_eff    = eff_len(len, LEN_W'(W));
  assign w_cap_al = pattern << (LEN_W'(W) - w_eff);

  // The shift register holds the bits still to come; the bit on dout lives in r_dout.
  piso_shreg #(.W(W)) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .shift (w_shift),
    .din   (w_din),
    .msb   (w_msb)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_din       = {r_pat_al[W-2:0], 1'b0};
    w_dout_nxt  = IDLE_LEVEL;
    w_capture   = 1'b0;
    w_reload    = 1'b0;
    w_bit_dec   = 1'b0;
    w_rep_dec   = 1'b0;
    w_gap_load  = 1'b0;
    w_gap_dec   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_state_nxt = SHIFT;
          w_capture   = 1'b1;
          w_load      = 1'b1;
          w_din       = {w_cap_al[W-2:0], 1'b0};
          w_dout_nxt  = w_cap_al[W-1];
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (r_bit_cnt != {BIT_W{1'b0}}) begin
          w_shift    = 1'b1;
          w_bit_dec  = 1'b1;
          w_dout_nxt = w_msb;
        end else if (r_rep != 4'd0) begin
          w_rep_dec = 1'b1;
          if (GAP_CYCLES == 0) begin
            w_state_nxt = SHIFT;
            w_load      = 1'b1;
            w_reload    = 1'b1;
            w_dout_nxt  = r_pat_al[W-1];
          end else begin
            w_state_nxt = GAP;
            w_gap_load  = 1'b1;
          end
        end else begin
          w_state_nxt = DONE;
        end
      end
      GAP: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (r_gap_cnt != {GAP_W{1'b0}}) begin
          w_gap_dec = 1'b1;
        end else begin
          w_state_nxt = SHIFT;
          w_load      = 1'b1;
          w_reload    = 1'b1;
          w_dout_nxt  = r_pat_al[W-1];
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Captured transaction values and the bit/repeat/gap counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pat_al  <= {W{1'b0}};
      r_len     <= {BIT_W{1'b0}};
      r_bit_cnt <= {BIT_W{1'b0}};
      r_rep     <= 4'd0;
      r_gap_cnt <= {GAP_W{1'b0}};
    end else begin
      if (w_capture) begin
        r_pat_al  <= w_cap_al;
        r_len     <= BIT_W'(w_eff);
        r_rep     <= repeat_n;
        r_bit_cnt <= BIT_W'(w_eff) - BIT_W'(1);
      end else if (w_reload) begin
        r_bit_cnt <= r_len - BIT_W'(1);
      end else if (w_bit_dec) begin
        r_bit_cnt <= r_bit_cnt - BIT_W'(1);
      end
      if (w_rep_dec) begin
        r_rep <= r_rep - 4'd1;
      end
      if (w_gap_load) begin
        r_gap_cnt <= GAP_LOAD;
      end else if (w_gap_dec) begin
        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      end
    end
  end

  // Output flops are loaded from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout       <= IDLE_LEVEL;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_dout       <= w_dout_nxt;
      r_dout_valid <= (w_state_nxt == SHIFT);
      r_busy       <= (w_state_nxt == SHIFT) || (w_state_nxt == GAP);
      r_done       <= (w_state_nxt == DONE);
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: directed scenarios plus random
// transactions compared cycle by cycle against a frame-level reference model.
module tb_seq_pattern_tx;

  localparam int TB_W   = 8;
  localparam int TB_GAP = 2;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic [4:0] len;
  logic [3:0] repeat_n;
  logic       dout;
  logic       dout_valid;
  logic       busy;
  logic       done;

  int n_checks;
  int n_errors;
  logic [3:0] exp_q[$];

  seq_pattern_tx #(.W(TB_W), .GAP_CYCLES(TB_GAP), .IDLE_LEVEL(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .pattern    (pattern),
    .len        (len),
    .repeat_n   (repeat_n),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] outs();
    return {dout, dout_valid, busy, done};
  endfunction

  // Expected {dout,valid,busy,done} per cycle, starting the cycle after start is sampled.
  task automatic build_exp(input logic [7:0] pat, input logic [4:0] ln, input logic [3:0] rep);
    int frame_len;
    exp_q.delete();
    frame_len = (ln == 5'd0 || int'(ln) > TB_W) ? TB_W : int'(ln);
    for (int f = 0; f <= int'(rep); f++) begin
      for (int i = frame_len - 1; i >= 0; i--) exp_q.push_back({pat[i], 1'b1, 1'b1, 1'b0});
      if (f < int'(rep)) begin
        for (int g = 0; g < TB_GAP; g++) exp_q.push_back(4'b1010);
      end
    end
    exp_q.push_back(4'b1001);
  endtask

  // Called just after a falling edge; returns just after a falling edge in IDLE.
  task automatic run_txn(input string tag, input logic [7:0] pat, input logic [4:0] ln,
                         input logic [3:0] rep, input bit noisy);
    int busy_cycles;
    int done_cycles;
    build_exp(pat, ln, rep);
    busy_cycles = 0;
    done_cycles = 0;
    start = 1'b1; abort = 1'b0; pattern = pat; len = ln; repeat_n = rep;
    foreach (exp_q[k]) begin
      @(negedge clk);
      check(tag, 32'(outs()), 32'(exp_q[k]));
      busy_cycles += int'(busy);
      done_cycles += int'(done);
      if (noisy) begin
        start    = 1'($urandom_range(0, 1));
        pattern  = 8'($urandom_range(0, 255));
        len      = 5'($urandom_range(0, 31));
        repeat_n = 4'($urandom_range(0, 15));
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    check({tag, "_idle"}, 32'(outs()), 32'h8);
    check({tag, "_done_count"}, 32'(done_cycles), 32'd1);
    check({tag, "_busy_count"}, 32'(busy_cycles), 32'(exp_q.size() - 1));
    start = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    pattern = 8'h00; len = 5'd0; repeat_n = 4'd0;
    repeat (2) @(negedge clk);
    check("reset", 32'(outs()), 32'h8);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 32'(outs()), 32'h8);

    run_txn("len3", 8'h01, 5'd3, 4'd0, 1'b0);
    run_txn("len0_a5", 8'hA5, 5'd0, 4'd0, 1'b0);
    run_txn("rep2_gap", 8'h01, 5'd3, 4'd2, 1'b0);
    run_txn("len_over", 8'h96, 5'd20, 4'd1, 1'b0);

    // Abort in the second SHIFT cycle; a start with another pattern while busy is ignored.
    start = 1'b1; pattern = 8'hA5; len = 5'd8; repeat_n = 4'd0;
    @(negedge clk);
    check("abort_bit0", 32'(outs()), 32'hE);
    start = 1'b1; pattern = 8'h5A; len = 5'd2;
    @(negedge clk);
    check("abort_bit1", 32'(outs()), 32'h6);
    start = 1'b0; abort = 1'b1;
    @(negedge clk);
    check("abort_idle", 32'(outs()), 32'h8);
    abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_done", 32'(outs()), 32'h8);
    end

    // Asynchronous reset between edges in the middle of a frame.
    start = 1'b1; pattern = 8'hA5; len = 5'd0; repeat_n = 4'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("rst_async", 32'(outs()), 32'h8);
    @(negedge clk);
    check("rst_hold", 32'(outs()), 32'h8);
    reset = 1'b0;
    run_txn("after_rst", 8'h3C, 5'd6, 4'd1, 1'b0);

    // Start and abort together in IDLE.
    start = 1'b1; abort = 1'b1; pattern = 8'hFF; len = 5'd4;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("start_abort", 32'(outs()), 32'h8);
    end
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_rel", 32'(outs()), 32'h8);

    for (int t = 0; t < 12; t++) begin
      run_txn("rand", 8'($urandom_range(0, 255)), 5'($urandom_range(0, 31)),
              4'($urandom_range(0, 3)), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 The module SHALL have parameter W, default 8, giving the pattern register width in bits (2..16).
REQ-002 The module SHALL have parameter GAP_CYCLES, default 2, giving the idle-level cycles between repeated frames (0..15).
REQ-003 The module SHALL have parameter IDLE_LEVEL, default 1'b1, giving the dout level whenever no frame bit is driven.
REQ-004 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset, input, 1, an asynchronous active-high reset.
REQ-006 The module SHALL have port start, input, 1, a request to begin transmission, sampled only in IDLE.
REQ-007 The module SHALL have port abort, input, 1, a synchronous request to cancel transmission.
REQ-008 The module SHALL have port pattern, input, W, the frame bits; pattern[len-1:0] is transmitted.
REQ-009 The module SHALL have port len, input, 5, the frame length in bits.
REQ-010 The module SHALL have port repeat_n, input, 4, the number of extra frame repetitions (total frames = repeat_n+1).
REQ-011 The module SHALL have port dout, output, 1, the registered serial data bit.
REQ-012 The module SHALL have port dout_valid, output, 1, high only while dout carries a frame bit.
REQ-013 The module SHALL have port busy, output, 1, high from the first SHIFT cycle through the last SHIFT/GAP cycle.
REQ-014 The module SHALL have port done, output, 1, a one-cycle pulse after the final frame completes.

Function
REQ-015 The module SHALL be a Moore FSM with states IDLE, SHIFT, GAP and DONE, and all outputs SHALL be registered functions of state and datapath registers only.
REQ-016 In IDLE: dout=IDLE_LEVEL, dout_valid=0, busy=0, done=0; start=1 with abort=0 SHALL capture pattern, effective length and repeat_n, and SHALL enter SHIFT at that edge.
REQ-017 The first frame bit SHALL appear on dout in the cycle immediately after the edge that sampled start (latency 1).
REQ-018 The effective length SHALL be W when len=0 or len>W, and len otherwise.
REQ-019 In SHIFT the module SHALL emit one bit per cycle, MSB-first from pattern[L-1] down to pattern[0], with dout_valid=1 and busy=1.
REQ-020 After the last bit, if remaining repeats>0, the module SHALL decrement the repeat count, reload the captured pattern, and enter GAP (or SHIFT directly when GAP_CYCLES=0).
REQ-021 In GAP the module SHALL hold dout=IDLE_LEVEL, dout_valid=0 and busy=1 for exactly GAP_CYCLES cycles, then enter SHIFT.
REQ-022 After the last bit with remaining repeats=0, the module SHALL enter DONE for exactly one cycle (done=1, busy=0, dout=IDLE_LEVEL) and then enter IDLE.
REQ-023 While busy or in DONE, start SHALL be ignored and captured values SHALL NOT change.
REQ-024 abort=1 in SHIFT, GAP or DONE SHALL force IDLE at the next edge with no done pulse; abort=1 with start=1 in IDLE SHALL keep the FSM in IDLE.
REQ-025 Bit and gap counters SHALL be sized to hold W and GAP_CYCLES without wrap-around.
REQ-026 Unreachable state encodings SHALL return to IDLE at the next edge.

Reset
REQ-027 Asserting reset SHALL immediately force IDLE, dout=IDLE_LEVEL, dout_valid=0, busy=0, done=0, and clear all counters and the shift register, including mid-frame.
REQ-028 After reset deasserts, the first start SHALL be accepted at the first rising edge on which it is sampled high.

Structure
REQ-029 State encodings (IDLE=2'b00, SHIFT=2'b01, GAP=2'b10, DONE=2'b11) and the length-field width SHALL reside in shared package seq_tx_pkg.
REQ-030 The parallel-load, MSB-out shift register SHALL be a sub-module named piso_shreg (ports: clk, reset, load, shift, din[W-1:0], msb).

Verification
REQ-031 The bench SHALL cover: pattern=8'h01, len=3, repeat_n=0, one start pulse -> dout 0,0,1 with dout_valid=1 for 3 cycles, done=1 in cycle 4, then IDLE.
REQ-032 The bench SHALL cover: pattern=8'hA5, len=0 -> dout 1,0,1,0,0,1,0,1 over 8 cycles, then done pulse.
REQ-033 The bench SHALL cover: pattern=8'h01, len=3, repeat_n=2, GAP_CYCLES=2 -> 001, 2 gap cycles, 001, 2 gap cycles, 001; busy high for 13 cycles; exactly one done.
REQ-034 The bench SHALL cover: abort asserted in the second SHIFT cycle -> IDLE next cycle, dout=IDLE_LEVEL, no done; a start pulse during busy -> no effect.
REQ-035 The bench SHALL cover: reset asserted asynchronously mid-SHIFT (between edges) -> outputs at reset values before the next edge; a start after release -> a normal frame.
REQ-036 The bench SHALL cover: start=1 and abort=1 together in IDLE -> remains IDLE, busy stays 0.
